// File: rtl/pipe_feeder_pkg.sv
// Shared types and constants for the procedural obstacle source.
package pipe_feeder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GAP  = 2'd1,
      S_PIPE = 2'd2
   } state_t;

   localparam logic [15:0] LFSR_TAPS  = 16'hB400;
   localparam int          HEIGHT_W   = 2;
   localparam int          COUNT_W    = 8;
   localparam int          REM_W      = 5;
   localparam int          RAMP_FLOOR = 3;

   // One step of the right-shifting Galois LFSR.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   // Gap minimum shrunk by one column per 16 pipes, never below the floor.
   function automatic logic [REM_W-1:0] ramp_gap_min(input logic [REM_W-1:0] base,
                                                     input logic [3:0]       tier);
      logic [REM_W:0] diff;
      diff = {1'b0, base} - {2'b00, tier};
      if (diff[REM_W] || (diff < (REM_W+1)'(RAMP_FLOOR)))
         return REM_W'(RAMP_FLOOR);
      return diff[REM_W-1:0];
   endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 16-bit Galois LFSR with synchronous load and step; a zero load becomes SEED
// so the register can never lock up at zero.
module pipe_lfsr
   import pipe_feeder_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        step,
   output logic [15:0] value
);

   logic [15:0] lfsr_q;

   // Load wins over step; both are ignored while the register is in reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr_q <= SEED;
      end else if (load) begin
         lfsr_q <= (load_value != 16'h0000) ? load_value : SEED;
      end else if (step) begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign value = lfsr_q;

endmodule

// File: rtl/pipe_feeder.sv
// Endless pseudo-random column stream feeding the game datapath scroll register.
// Optional build macro PIPE_FEEDER_RAMP_EN: gap minimum shrinks as pipes accumulate.
module pipe_feeder
   import pipe_feeder_pkg::*;
#(
   parameter logic [15:0] SEED     = 16'hACE1,
   parameter int          GAP_MIN  = 8,
   parameter int          GAP_SPAN = 8,
   parameter int          PIPE_W   = 2
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic                move,
   input  logic                advance,
   input  logic [15:0]         seed_in,
   output logic [HEIGHT_W-1:0] col_height,
   output logic                col_valid,
   output logic [COUNT_W-1:0]  pipe_count
);

   localparam logic [REM_W-1:0] GAP_MIN_L = REM_W'(GAP_MIN);
   localparam logic [REM_W-1:0] PIPE_W_L  = REM_W'(PIPE_W);
   localparam logic [2:0]       SPAN_MASK = 3'(GAP_SPAN - 1);

   state_t              state_q, state_d;
   logic [REM_W-1:0]    col_rem_q, col_rem_d;
   logic [HEIGHT_W-1:0] height_q, height_d;
   logic                valid_q, valid_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic [15:0]         lfsr_value;
   logic                accept;
   logic [REM_W-1:0]    gap_min_eff;
   logic [REM_W-1:0]    gap_draw;
   logic [HEIGHT_W-1:0] height_draw;
   logic                lfsr_unused;

   assign accept = advance & move & ~start;

   pipe_lfsr #(.SEED(SEED)) u_lfsr (
      .clk        (clk),
      .resetn     (resetn),
      .load       (start),
      .load_value (seed_in),
      .step       (accept),
      .value      (lfsr_value)
   );

`ifdef PIPE_FEEDER_RAMP_EN
   assign gap_min_eff = ramp_gap_min(GAP_MIN_L, count_q[7:4]);
`else
   assign gap_min_eff = GAP_MIN_L;
`endif

   assign gap_draw    = gap_min_eff + {2'b00, lfsr_value[2:0] & SPAN_MASK};
   assign height_draw = (lfsr_value[9:8] == 2'b00) ? 2'b01 : lfsr_value[9:8];
   assign lfsr_unused = ^{lfsr_value[15:10], lfsr_value[7:3]};

   // State and output registers; everything freezes unless start or an accepted advance.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         col_rem_q <= '0;
         height_q  <= '0;
         valid_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         col_rem_q <= col_rem_d;
         height_q  <= height_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
      end
   end

   // Next column: draws use the LFSR value from before this advance steps it.
   always_comb begin
      state_d   = state_q;
      col_rem_d = col_rem_q;
      height_d  = height_q;
      valid_d   = valid_q;
      count_d   = count_q;
      if (start) begin
         state_d   = S_IDLE;
         col_rem_d = '0;
         height_d  = '0;
         valid_d   = 1'b0;
         count_d   = '0;
      end else if (accept) begin
         unique case (state_q)
            S_IDLE: begin
               state_d   = S_GAP;
               col_rem_d = gap_draw;
               height_d  = '0;
               valid_d   = 1'b1;
            end
            S_GAP: begin
               if (col_rem_q == REM_W'(1)) begin
                  state_d   = S_PIPE;
                  col_rem_d = PIPE_W_L;
                  height_d  = height_draw;
               end else begin
                  col_rem_d = col_rem_q - REM_W'(1);
               end
            end
            S_PIPE: begin
               if (col_rem_q == REM_W'(1)) begin
                  state_d   = S_GAP;
                  col_rem_d = gap_draw;
                  height_d  = '0;
                  if (count_q != {COUNT_W{1'b1}}) begin
                     count_d = count_q + COUNT_W'(1);
                  end
               end else begin
                  col_rem_d = col_rem_q - REM_W'(1);
               end
            end
            default: begin
               state_d   = S_IDLE;
               col_rem_d = '0;
               height_d  = '0;
               valid_d   = 1'b0;
            end
         endcase
      end
   end

   assign col_height = height_q;
   assign col_valid  = valid_q;
   assign pipe_count = count_q;

endmodule
